// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative cache with true-LRU replacement.
//   WRITE_THROUGH=0 : write-back / write-allocate, per-line dirty bits.
//   WRITE_THROUGH=1 : write-through / write-allocate, every write hit is
//                     pushed to memory as a full block before completing.
// Ports:
//   clk, proc_reset               clock, synchronous active-high reset
//   proc_read/proc_write/proc_addr/proc_wdata  processor request (held while stalled)
//   proc_stall, proc_rdata        processor response
//   mem_read/mem_write/mem_addr/mem_wdata      block request to memory
//   mem_rdata, mem_ready          block response from memory (ready is a 1-cycle pulse)
//   hit_count, miss_count         saturating performance counters
module assoc_cache #(
  parameter int NUM_SETS      = 4,
  parameter int NUM_WAYS      = 2,
  parameter int WRITE_THROUGH = 0,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             proc_reset,
  input  logic             proc_read,
  input  logic             proc_write,
  input  logic [29:0]      proc_addr,
  input  logic [31:0]      proc_wdata,
  output logic             proc_stall,
  output logic [31:0]      proc_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [27:0]      mem_addr,
  output logic [127:0]     mem_wdata,
  input  logic [127:0]     mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 28 - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;
  localparam logic [1:0] S_WT    = 2'd3;

  // Storage
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [127:0]        data_q  [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];

  // Control
  logic [1:0]       state_q, state_d;
  logic [WAY_W-1:0] way_q;        // way being filled / evicted / written through
  logic             missed_q;     // current request already took a miss
  logic [CNT_W-1:0] hit_q, miss_q;

  // Request decode
  logic             req_s, wr_s;
  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic [1:0]       word_s;

  assign req_s  = proc_read | proc_write;
  assign wr_s   = proc_write;           // read+write together is a write
  assign idx_s  = proc_addr[IDX_W+1:2];
  assign tag_s  = proc_addr[29:IDX_W+2];
  assign word_s = proc_addr[1:0];

  logic             hit_s;
  logic [WAY_W-1:0] hit_way_s;
  logic [WAY_W-1:0] hit_age_s;
  logic             found_s;
  logic [WAY_W-1:0] inv_way_s, max_way_s, max_age_s, victim_s;
  logic             hit_ev_s, miss_ev_s, wr_hit_s, done_s;

  // Tag compare across all ways of the indexed set
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = WAY_W'(w);
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  assign hit_age_s = age_q[idx_s][hit_way_s];

  // Victim choice: lowest-index invalid way, else the oldest way
  always_comb begin
    found_s   = 1'b0;
    inv_way_s = '0;
    max_way_s = '0;
    max_age_s = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!valid_q[idx_s][w] && !found_s) begin
        inv_way_s = WAY_W'(w);
        found_s   = 1'b1;
      end else begin
        found_s   = found_s;
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (age_q[idx_s][w] > max_age_s) begin
        max_age_s = age_q[idx_s][w];
        max_way_s = WAY_W'(w);
      end else begin
        max_age_s = max_age_s;
      end
    end
    if (found_s) begin
      victim_s = inv_way_s;
    end else begin
      victim_s = max_way_s;
    end
  end

  assign hit_ev_s  = (state_q == S_IDLE) && req_s && hit_s;
  assign miss_ev_s = (state_q == S_IDLE) && req_s && !hit_s;
  assign wr_hit_s  = hit_ev_s && wr_s;
  // A write-through write hit only completes once memory has accepted the block
  assign done_s    = (hit_ev_s && !((WRITE_THROUGH != 0) && wr_s)) ||
                     ((state_q == S_WT) && mem_ready);

  // Next state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = proc_addr[29:2];
    mem_wdata  = data_q[idx_s][way_q];
    case (state_q)
      S_IDLE: begin
        if (req_s && hit_s) begin
          if ((WRITE_THROUGH != 0) && wr_s) begin
            proc_stall = 1'b1;
            state_d    = S_WT;
          end else begin
            proc_stall = 1'b0;
          end
        end else if (req_s) begin
          proc_stall = 1'b1;
          if ((WRITE_THROUGH == 0) && valid_q[idx_s][victim_s] && dirty_q[idx_s][victim_s]) begin
            state_d = S_WB;
          end else begin
            state_d = S_ALLOC;
          end
        end else begin
          proc_stall = 1'b0;
        end
      end
      S_WB: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[idx_s][way_q], idx_s};
        if (mem_ready) begin
          state_d = S_ALLOC;
        end else begin
          state_d = S_WB;
        end
      end
      S_ALLOC: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        if (mem_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ALLOC;
        end
      end
      S_WT: begin
        // Release the processor in the same cycle memory accepts the block
        proc_stall = ~mem_ready;
        mem_write  = 1'b1;
        if (mem_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign proc_rdata = data_q[idx_s][hit_way_s][{word_s, 5'd0} +: 32];
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // Valid, dirty and LRU age bookkeeping
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      if (hit_ev_s && (NUM_WAYS > 1)) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == hit_way_s) begin
            age_q[idx_s][w] <= '0;
          end else if (age_q[idx_s][w] < hit_age_s) begin
            age_q[idx_s][w] <= age_q[idx_s][w] + WAY_W'(1);
          end
        end
      end
      if (wr_hit_s && (WRITE_THROUGH == 0)) begin
        dirty_q[idx_s][hit_way_s] <= 1'b1;
      end
      if ((state_q == S_WB) && mem_ready) begin
        dirty_q[idx_s][way_q] <= 1'b0;
      end
      if ((state_q == S_ALLOC) && mem_ready) begin
        valid_q[idx_s][way_q] <= 1'b1;
        dirty_q[idx_s][way_q] <= 1'b0;
      end
    end
  end

  // Line data and tags (not reset; guarded by valid)
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      // transfer abandoned: nothing is written
    end else if ((state_q == S_ALLOC) && mem_ready) begin
      data_q[idx_s][way_q] <= mem_rdata;
      tag_q[idx_s][way_q]  <= tag_s;
    end else if (wr_hit_s) begin
      data_q[idx_s][hit_way_s][{word_s, 5'd0} +: 32] <= proc_wdata;
    end
  end

  // FSM, active way, miss flag and saturating counters
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= S_IDLE;
      way_q    <= '0;
      missed_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q <= state_d;
      if (miss_ev_s) begin
        way_q    <= victim_s;
        missed_q <= 1'b1;
        if (miss_q != {CNT_W{1'b1}}) begin
          miss_q <= miss_q + CNT_W'(1);
        end
      end else if (hit_ev_s) begin
        way_q <= hit_way_s;
      end
      // The replay hit after a fill is not a new hit
      if (hit_ev_s && !missed_q && (hit_q != {CNT_W{1'b1}})) begin
        hit_q <= hit_q + CNT_W'(1);
      end
      if (done_s) begin
        missed_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
Parametrised N-way set-associative cache with true-LRU replacement and a selectable write policy (write-back/write-allocate or write-through/write-allocate). Sits between the processor data port and a 4-word-block memory, or between an upper cache and memory. Exposes the same processor and memory handshake used elsewhere in the memory hierarchy. Adds saturating hit/miss performance counters.

Parameters:
NUM_SETS, 4, number of sets; power of 2, >=2; IDX_W = log2(NUM_SETS)
NUM_WAYS, 2, associativity; one of 1, 2, 4
WRITE_THROUGH, 0, 0 = write-back with dirty bits; 1 = write-through, no dirty bits
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  clock; all state changes on rising edge
proc_reset  input  1  synchronous, active-high reset
proc_read  input  1  read request, held until proc_stall low
proc_write  input  1  write request, held until proc_stall low
proc_addr  input  30  word address: [1:0] word-in-block, [IDX_W+1:2] index, [29:IDX_W+2] tag
proc_wdata  input  32  write data
proc_stall  output  1  high while the current request cannot complete
proc_rdata  output  32  read data, valid when proc_read=1 and proc_stall=0
mem_read  output  1  block read request, held until mem_ready
mem_write  output  1  block write request, held until mem_ready
mem_addr  output  28  block address {tag,index}
mem_wdata  output  128  block write data, word 0 in [31:0]
mem_rdata  input  128  block read data, valid with mem_ready
mem_ready  input  1  one-cycle completion pulse from memory
hit_count  output  CNT_W  saturating count of hits
miss_count  output  CNT_W  saturating count of misses

Behaviour:
- Storage per set/way: valid, dirty (WRITE_THROUGH=0 only), tag, 128-bit data. Per set: LRU age per way (log2(NUM_WAYS) bits; 0 = MRU).
- Reset: every valid and dirty bit cleared; ages initialised to way index; FSM to IDLE; mem_read=0, mem_write=0, counters=0. proc_stall is 0 after reset when no request is present. Reset mid-operation abandons the transfer; mem_read/mem_write are low from the cycle after the reset edge.
- Request = proc_read | proc_write. If both are high, the request is treated as a write.
- FSM states: IDLE, WRITEBACK, ALLOCATE, WT_WRITE.
- IDLE, hit (valid & tag match in any way): proc_stall=0 combinationally. Read: proc_rdata = selected word, zero wait states. Write: the word updates at the edge. Dirty is set if WRITE_THROUGH=0. If WRITE_THROUGH=1, go to WT_WRITE.
- On every hit, the hit way's age becomes 0; ages lower than the old age increment by 1.
- IDLE, miss: proc_stall=1. Victim = first invalid way (lowest index); otherwise the way with the maximum age. If the victim is valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE. miss_count increments once on this transition.
- WRITEBACK: mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim data. On mem_ready, clear dirty and go to ALLOCATE.
- ALLOCATE: mem_read=1, mem_addr=proc_addr[29:2]. On mem_ready, load mem_rdata into the victim, set valid, clear dirty, set tag, and return to IDLE. The request then hits in IDLE; that replay hit is not counted in hit_count.
- WT_WRITE: proc_stall=1, mem_write=1, mem_addr=proc_addr[29:2], mem_wdata=the updated line. On mem_ready, return to IDLE with proc_stall=0 in the same cycle. The write completes and is counted as one hit. proc_write must drop or change after that.
- mem_read and mem_write are never both high. Both are decoded from state only, so neither depends combinationally on mem_ready.
- hit_count increments on an IDLE hit, except the replay of a miss. A missed-flag is set on the miss transition and cleared when the request completes. In write-through mode a write hit counts once, on entry to WT_WRITE.
- Counters saturate at 2^CNT_W-1 and never wrap.
- NUM_WAYS=1 degenerates to direct-mapped; LRU logic is unused.
- mem_ready outside WRITEBACK, ALLOCATE or WT_WRITE is ignored.

Test Plan:
1. Reset, then read 0x0000010 (all invalid) -> stall, mem_read with mem_addr=0x0000004; memory returns {D,C,B,A} -> next cycle stall=0, proc_rdata=A; miss_count=1, hit_count=0.
2. Read 0x0000011 after test 1 -> zero-wait hit, proc_rdata=B, hit_count=1.
3. NUM_WAYS=2, WRITE_THROUGH=0: fill both ways of set 0, write one line, then miss on a third tag -> LRU way evicted. Dirty victim produces mem_write with the old block address and modified data before mem_read.
4. WRITE_THROUGH=1: write hit 0xDEADBEEF to 0x0000012 -> stall until mem_ready, mem_wdata[95:64]=0xDEADBEEF, no dirty writeback on later eviction.
5. Assert proc_reset during ALLOCATE -> mem_read low next cycle. Valid bits are cleared, so the same address misses again.
6. CNT_W=4: 20 consecutive hits -> hit_count holds at 15.
